sdram_word_bridge: RTL and testbench

- CPU-side initiator for the byte-wide SDRAM controller's request/done handshake.
- Accepts one 32-bit word read or byte-enabled word write from the CPU bus.
- Splits it into sequential single-byte controller transactions, one outstanding at a time, and reassembles read data.
- Sits between the core's memory stage and the SDRAM controller, with a watchdog so a stalled controller cannot hang the CPU.

---
 rtl/sdram_word_bridge_if.sv | 30 +++
 rtl/sdram_word_bridge.sv | 128 ++++++++++++
 tb/tb_sdram_word_bridge.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_word_bridge_if.sv
// rtl/sdram_word_bridge_if.sv - CPU bus and SDRAM controller handshake signals of the word bridge
interface sdram_word_bridge_if;
    logic        i_cpu_req;
    logic        i_cpu_wren;
    logic [22:0] i_cpu_addr;
    logic [31:0] i_cpu_wdata;
    logic [3:0]  i_cpu_be;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_done;
    logic        o_cpu_err;
    logic        o_cpu_busy;
    logic        o_mem_request;
    logic        o_mem_wren;
    logic [22:0] o_mem_address;
    logic [7:0]  o_mem_data;
    logic [7:0]  i_mem_data;
    logic        i_mem_done;

    modport master (
        output i_cpu_req, i_cpu_wren, i_cpu_addr, i_cpu_wdata, i_cpu_be, i_mem_data, i_mem_done,
        input  o_cpu_rdata, o_cpu_done, o_cpu_err, o_cpu_busy,
               o_mem_request, o_mem_wren, o_mem_address, o_mem_data
    );

    modport slave (
        input  i_cpu_req, i_cpu_wren, i_cpu_addr, i_cpu_wdata, i_cpu_be, i_mem_data, i_mem_done,
        output o_cpu_rdata, o_cpu_done, o_cpu_err, o_cpu_busy,
               o_mem_request, o_mem_wren, o_mem_address, o_mem_data
    );
endinterface

// File: rtl/sdram_word_bridge.sv
// rtl/sdram_word_bridge.sv - splits a CPU word access into byte transactions on the SDRAM controller
module sdram_word_bridge #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sdram_word_bridge_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          wren_q;
    logic [20:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [2:0]    lane;
    logic [CW-1:0] timer;
    logic          err_q;
    logic [31:0]   shadow;
    logic [31:0]   rdata_q;
    logic          mem_wren_q;
    logic [22:0]   mem_addr_q;
    logic [7:0]    mem_data_q;
    logic          timeout_hit;
    logic          unused_addr_lsbs;

    assign timeout_hit      = (timer == CW'(TIMEOUT_CYCLES - 1));
    assign unused_addr_lsbs = ^bus.i_cpu_addr[1:0];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.i_cpu_req) state_next = S_SCAN;
            // lane[2] set means all four lanes have been visited
            S_SCAN: begin
                if (lane[2])
                    state_next = S_FINISH;
                else if (be_q[lane[1:0]])
                    state_next = S_ISSUE;
            end
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (bus.i_mem_done)
                    state_next = S_SCAN;
                else if (timeout_hit)
                    state_next = S_FINISH;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            lane       <= '0;
            timer      <= '0;
            err_q      <= 1'b0;
            shadow     <= '0;
            rdata_q    <= '0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (bus.i_cpu_req) begin
                        wren_q  <= bus.i_cpu_wren;
                        addr_q  <= bus.i_cpu_addr[22:2];
                        wdata_q <= bus.i_cpu_wdata;
                        be_q    <= bus.i_cpu_wren ? bus.i_cpu_be : 4'b1111;
                        lane    <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (lane[2]) begin
                        if (!wren_q)
                            rdata_q <= shadow;
                    end else if (be_q[lane[1:0]]) begin
                        // controller-side fields are held until the byte leaves WAIT
                        mem_addr_q <= {addr_q, lane[1:0]};
                        mem_wren_q <= wren_q;
                        mem_data_q <= wdata_q[{lane[1:0], 3'b000} +: 8];
                        timer      <= '0;
                    end else begin
                        lane <= lane + 3'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.i_mem_done) begin
                        if (!wren_q)
                            shadow[{lane[1:0], 3'b000} +: 8] <= bus.i_mem_data;
                        lane <= lane + 3'd1;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_mem_request = (state == S_ISSUE);
    assign bus.o_mem_wren    = mem_wren_q;
    assign bus.o_mem_address = mem_addr_q;
    assign bus.o_mem_data    = mem_data_q;
    assign bus.o_cpu_done    = (state == S_FINISH);
    assign bus.o_cpu_err     = (state == S_FINISH) && err_q;
    assign bus.o_cpu_busy    = (state != S_IDLE);
    assign bus.o_cpu_rdata   = rdata_q;
endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb/tb_sdram_word_bridge.sv - directed bench for sdram_word_bridge with a word-level reference model
module tb_sdram_word_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_word_bridge_if bus ();
    sdram_word_bridge_if t_bus ();

    sdram_word_bridge dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    sdram_word_bridge #(.TIMEOUT_CYCLES(16)) dut_t (.i_clk(clk), .i_reset(rst), .bus(t_bus));

    int n_vec = 0;
    int n_bad = 0;
    int ncyc = 0;
    logic [7:0] mem [0:1023];
    int d_cycles = 7;
    int stall_lane = -1;
    int stall_extra = 0;

    bit          active = 1'b0;
    int          req_n;
    int          exp_lat;
    bit          exp_w;
    logic [20:0] exp_base;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [9:0]  b10;
    logic [31:0] got_rdata;
    int          got_lat;
    int          got_reqs;
    int          op_reqs = 0;
    int          ops_done = 0;
    int          reqs_total = 0;

    bit          pend = 1'b0;
    int          cnt;
    logic [22:0] paddr;
    bit          pwren;
    logic [7:0]  pdata;
    int          last_done = -100;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // controller model plus word-level reference, evaluated once per cycle
    always @(negedge clk) begin
        ncyc++;
        if (ncyc == 1) begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5);
            mem[10'h104] = 8'h11;
            mem[10'h105] = 8'h22;
            mem[10'h106] = 8'h33;
            mem[10'h107] = 8'h44;
        end
        bus.i_mem_done = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.i_mem_done = 1'b1;
                bus.i_mem_data = mem[paddr[9:0]];
                if (pwren) mem[paddr[9:0]] = pdata;
                pend = 1'b0;
                last_done = ncyc;
            end
        end
        if (rst) begin
            active = 1'b0;
            exp_q.delete();
            exp_rdata = '0;
        end else begin
            chk("busy", bus.o_cpu_busy, active);
            if (bus.o_mem_request) begin
                reqs_total++;
                op_reqs++;
                chk("req_spacing", (ncyc - last_done) >= 2, 1);
                chk("req_single_outstanding", pend, 0);
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("req_fields", {bus.o_mem_address, bus.o_mem_wren, e[8] ? bus.o_mem_data : 8'h00}, e);
                end
                pend  = 1'b1;
                cnt   = d_cycles + ((int'(bus.o_mem_address[1:0]) == stall_lane) ? stall_extra : 0);
                paddr = bus.o_mem_address;
                pwren = bus.o_mem_wren;
                pdata = bus.o_mem_data;
            end
            if (bus.o_cpu_done) begin
                chk("done_expected", active, 1);
                if (active) begin
                    if (!exp_w) begin
                        b10 = {exp_base[7:0], 2'b00};
                        exp_rdata = {mem[b10 + 10'd3], mem[b10 + 10'd2], mem[b10 + 10'd1], mem[b10]};
                    end
                    chk("rdata", bus.o_cpu_rdata, exp_rdata);
                    chk("err", bus.o_cpu_err, 0);
                    chk("latency", ncyc - req_n, exp_lat);
                    chk("all_lanes_issued", exp_q.size(), 0);
                    got_rdata = bus.o_cpu_rdata;
                    got_lat   = ncyc - req_n;
                    got_reqs  = op_reqs;
                    ops_done++;
                    active = 1'b0;
                end
            end
            if (bus.i_cpu_req && !active) begin
                active   = 1'b1;
                req_n    = ncyc;
                op_reqs  = 0;
                exp_w    = bus.i_cpu_wren;
                exp_base = bus.i_cpu_addr[22:2];
                exp_lat  = 2;
                exp_q.delete();
                for (int k = 0; k < 4; k++) begin
                    if (!exp_w || bus.i_cpu_be[k]) begin
                        exp_q.push_back({exp_base, 2'(k), exp_w, exp_w ? bus.i_cpu_wdata[8*k +: 8] : 8'h00});
                        exp_lat += d_cycles + 2 + ((k == stall_lane) ? stall_extra : 0);
                    end else begin
                        exp_lat += 1;
                    end
                end
            end
        end
    end

    task automatic issue_op(input bit w, input logic [22:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(posedge clk); #2;
        bus.i_cpu_req   = 1'b1;
        bus.i_cpu_wren  = w;
        bus.i_cpu_addr  = a;
        bus.i_cpu_wdata = wd;
        bus.i_cpu_be    = be;
        @(posedge clk); #2;
        bus.i_cpu_req = 1'b0;
    endtask

    task automatic wait_op(input int start, input int bound);
        for (int i = 0; i < bound && ops_done == start; i++) @(posedge clk);
        #2;
        chk("op_completed", ops_done - start, 1);
    endtask

    task automatic do_op(input bit w, input logic [22:0] a, input logic [31:0] wd, input logic [3:0] be);
        int start;
        start = ops_done;
        issue_op(w, a, wd, be);
        wait_op(start, 3000);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic t_run(input bit respond, output int reqs, output int done_at,
                         output logic err, output logic [31:0] rd);
        bit tpend;
        tpend = 1'b0;
        reqs = 0;
        done_at = -1;
        err = 1'b0;
        rd = '0;
        @(posedge clk); #2;
        t_bus.i_cpu_req = 1'b1;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            @(posedge clk); #2;
            t_bus.i_cpu_req  = 1'b0;
            t_bus.i_mem_done = 1'b0;
            if (t_bus.o_cpu_done) begin
                done_at = k;
                err = t_bus.o_cpu_err;
                rd = t_bus.o_cpu_rdata;
            end
            if (t_bus.o_mem_request) begin
                reqs++;
                tpend = respond;
            end else if (tpend) begin
                t_bus.i_mem_done = 1'b1;
                t_bus.i_mem_data = 8'hA0 + 8'(reqs);
                tpend = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int tr;
        int td;
        int extra;
        int start;
        logic te;
        logic [31:0] trd;

        bus.i_cpu_req = 1'b1;
        bus.i_cpu_wren = 1'b0;
        bus.i_cpu_addr = 23'h000104;
        bus.i_cpu_wdata = '0;
        bus.i_cpu_be = 4'hF;
        t_bus.i_cpu_req = 1'b0;
        t_bus.i_cpu_wren = 1'b0;
        t_bus.i_cpu_addr = 23'h000300;
        t_bus.i_cpu_wdata = '0;
        t_bus.i_cpu_be = 4'h0;
        t_bus.i_mem_data = '0;
        t_bus.i_mem_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        bus.i_cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs", {bus.o_cpu_rdata, bus.o_cpu_done, bus.o_cpu_err, bus.o_cpu_busy,
            bus.o_mem_request, bus.o_mem_wren, bus.o_mem_address, bus.o_mem_data}, 0);
        chk("reset_outputs_t", {t_bus.o_cpu_rdata, t_bus.o_cpu_done, t_bus.o_cpu_err, t_bus.o_cpu_busy,
            t_bus.o_mem_request, t_bus.o_mem_wren, t_bus.o_mem_address, t_bus.o_mem_data}, 0);

        d_cycles = 7;
        do_op(1'b0, 23'h000104, 32'h0, 4'h0);
        chk("t1_rdata", got_rdata, 32'h44332211);
        chk("t1_latency", got_lat, 38);
        chk("t1_reqs", got_reqs, 4);

        d_cycles = 3;
        do_op(1'b1, 23'h000200, 32'hA1B2C3D4, 4'b0101);
        chk("t2_reqs", got_reqs, 2);
        chk("t2_mem_lane0", mem[10'h200], 8'hD4);
        chk("t2_mem_lane2", mem[10'h202], 8'hB2);
        do_op(1'b0, 23'h000200, 32'h0, 4'h0);

        do_op(1'b1, 23'h000300, 32'hFFFFFFFF, 4'b0000);
        chk("t3_reqs", got_reqs, 0);
        chk("t3_latency_within_7", got_lat <= 7, 1);

        d_cycles = 1;
        do_op(1'b0, 23'h00010B, 32'h0, 4'h0);
        chk("t4_latency", got_lat, 14);

        for (int b = 1; b < 16; b++) begin
            d_cycles = 1 + (b % 3);
            do_op(1'b1, 23'h000040, 32'h9A8B7C6D ^ {8{4'(b)}}, 4'(b));
            do_op(1'b0, 23'h000040, 32'h0, 4'h0);
        end

        t_run(1'b1, tr, td, te, trd);
        chk("tt_good_reqs", tr, 4);
        chk("tt_good_rdata", trd, 32'hA4A3A2A1);
        chk("tt_good_err", te, 0);
        t_run(1'b0, tr, td, te, trd);
        chk("tt_timeout_reqs", tr, 1);
        chk("tt_timeout_done_at", td, 18);
        chk("tt_timeout_err", te, 1);
        chk("tt_timeout_rdata", trd, 32'hA4A3A2A1);
        repeat (2) @(posedge clk);
        #2;
        t_bus.i_mem_done = 1'b1;
        t_bus.i_mem_data = 8'hEE;
        @(posedge clk); #2;
        t_bus.i_mem_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (t_bus.o_cpu_done || t_bus.o_mem_request || t_bus.o_cpu_busy) extra++;
        end
        chk("tt_late_done_ignored", extra, 0);
        chk("tt_rdata_held", t_bus.o_cpu_rdata, 32'hA4A3A2A1);

        d_cycles = 2;
        stall_lane = 2;
        stall_extra = 700;
        start = ops_done;
        issue_op(1'b0, 23'h000004, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #2;
        bus.i_cpu_req = 1'b1;
        bus.i_cpu_wren = 1'b1;
        bus.i_cpu_addr = 23'h0007F0;
        bus.i_cpu_wdata = 32'hDEADBEEF;
        bus.i_cpu_be = 4'hF;
        @(posedge clk); #2;
        bus.i_cpu_req = 1'b0;
        wait_op(start, 2000);
        chk("t6_reqs", got_reqs, 4);
        chk("t6_latency", got_lat, 718);
        stall_lane = -1;
        stall_extra = 0;
        repeat (4) @(posedge clk);

        d_cycles = 7;
        start = reqs_total;
        issue_op(1'b0, 23'h000108, 32'h0, 4'h0);
        for (int i = 0; i < 200 && reqs_total < start + 2; i++) @(posedge clk);
        chk("t7_byte1_issued", reqs_total - start, 2);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t7_reset_outputs", {bus.o_cpu_rdata, bus.o_cpu_done, bus.o_cpu_err, bus.o_cpu_busy,
            bus.o_mem_request, bus.o_mem_wren, bus.o_mem_address, bus.o_mem_data}, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        do_op(1'b0, 23'h000108, 32'h0, 4'h0);
        chk("t7_reqs_after_reset", got_reqs, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
